seq_shift_add_mult: RTL and testbench

//  Parametrised iterative shift-and-add multiplier, next generation of the repeated-addition

---
 rtl/seq_shift_add_mult.sv | 98 +++++++++
 tb/tb_seq_shift_add_mult.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seq_shift_add_mult.sv
// Iterative shift-and-add multiplier: one multiplier bit per cycle with early exit,
// signed/unsigned operands via magnitude multiply plus final sign fix, start/busy/done handshake.
module seq_shift_add_mult #(
    parameter int WIDTH     = 8,
    parameter int SIGNED_EN = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t               state;
    logic                 neg;
    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mplr;
    logic [2*WIDTH-1:0]   acc;
    logic [CNT_W-1:0]     cnt;
    logic                 sm_eff;

    // Magnitude fits in WIDTH unsigned bits, including the most negative value.
    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] x, input logic sm);
        return (sm && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
    endfunction

    function automatic logic [2*WIDTH-1:0] apply_sign(input logic [2*WIDTH-1:0] x, input logic n);
        return n ? (~x + (2*WIDTH)'(1)) : x;
    endfunction

    assign sm_eff = signed_mode && (SIGNED_EN != 0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            neg     <= 1'b0;
            mcand   <= '0;
            mplr    <= '0;
            acc     <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        neg   <= sm_eff && (a[WIDTH-1] ^ b[WIDTH-1]);
                        mcand <= {{WIDTH{1'b0}}, mag(a, sm_eff)};
                        mplr  <= mag(b, sm_eff);
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= CALC;
                    end
                end
                // Leave as soon as no set multiplier bits remain, so latency tracks |b|.
                CALC: begin
                    if (mplr[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt + CNT_W'(1);
                    if ((mplr >> 1) == '0 || cnt == CNT_LAST) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    product <= apply_sign(acc, neg);
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Directed bench for seq_shift_add_mult: an 8-bit signed-capable instance and a
// 16-bit unsigned-only instance, with hand-computed products and latencies.
module tb_seq_shift_add_mult;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        start = 1'b0;
    logic        signed_mode = 1'b0;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic        busy;
    logic        done;
    logic [15:0] product;

    logic        start2 = 1'b0;
    logic        signed_mode2 = 1'b0;
    logic [15:0] a2 = '0;
    logic [15:0] b2 = '0;
    logic        busy2;
    logic        done2;
    logic [31:0] product2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    seq_shift_add_mult #(.WIDTH(8), .SIGNED_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .signed_mode(signed_mode),
        .a(a), .b(b), .busy(busy), .done(done), .product(product)
    );

    seq_shift_add_mult #(.WIDTH(16), .SIGNED_EN(0)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start2), .signed_mode(signed_mode2),
        .a(a2), .b(b2), .busy(busy2), .done(done2), .product(product2)
    );

    // Issue one operation on the 8-bit unit; lat = edges after the accepting edge until done (-1 on timeout).
    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tsm,
                          output logic [15:0] prod, output int lat);
        @(negedge clk);
        start = 1'b1; a = ta; b = tb_v; signed_mode = tsm;
        @(negedge clk);
        start = 1'b0; a = 8'($urandom); b = 8'($urandom); signed_mode = 1'($urandom);
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!done) lat = -1;
        prod = product;
    endtask

    task automatic run_op16(input logic [15:0] ta, input logic [15:0] tb_v, input logic tsm,
                            output logic [31:0] prod, output int lat);
        @(negedge clk);
        start2 = 1'b1; a2 = ta; b2 = tb_v; signed_mode2 = tsm;
        @(negedge clk);
        start2 = 1'b0; a2 = 16'($urandom); b2 = 16'($urandom);
        lat = 0;
        while (!done2 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!done2) lat = -1;
        prod = product2;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (product !== 16'h0000) begin failures++; $display("FAIL reset_product got=%h exp=0000", product); end
        checks++; if (busy2 !== 1'b0 || done2 !== 1'b0 || product2 !== 32'h0)
            begin failures++; $display("FAIL reset_w16 busy=%b done=%b product=%h exp 0/0/0", busy2, done2, product2); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned();
        logic [15:0] p; int lat;
        run_op(8'd255, 8'd255, 1'b0, p, lat);
        checks++; if (p !== 16'hFE01) begin failures++; $display("FAIL u255x255 got=%h exp=FE01", p); end
        checks++; if (lat !== 9) begin failures++; $display("FAIL u255x255_lat got=%0d exp=9", lat); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL busy_in_done got=%b exp=0", busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_width got=%b exp=0", done); end
        checks++; if (product !== 16'hFE01) begin failures++; $display("FAIL product_hold got=%h exp=FE01", product); end
        run_op(8'hFD, 8'd5, 1'b0, p, lat);
        checks++; if (p !== 16'h04F1) begin failures++; $display("FAIL u253x5 got=%h exp=04F1", p); end
        run_op(8'd2, 8'h80, 1'b0, p, lat);
        checks++; if (p !== 16'h0100 || lat !== 9) begin failures++; $display("FAIL u2x128 got=%h lat=%0d exp=0100 lat=9", p, lat); end
    endtask

    task automatic test_signed();
        logic [15:0] p; int lat;
        run_op(8'hFD, 8'd5, 1'b1, p, lat);
        checks++; if (p !== 16'hFFF1) begin failures++; $display("FAIL sm3x5 got=%h exp=FFF1", p); end
        checks++; if (lat !== 4) begin failures++; $display("FAIL sm3x5_lat got=%0d exp=4", lat); end
        run_op(8'h80, 8'h80, 1'b1, p, lat);
        checks++; if (p !== 16'h4000) begin failures++; $display("FAIL sm128xm128 got=%h exp=4000", p); end
        checks++; if (lat !== 9) begin failures++; $display("FAIL sm128xm128_lat got=%0d exp=9", lat); end
        run_op(8'h7F, 8'h80, 1'b1, p, lat);
        checks++; if (p !== 16'hC080) begin failures++; $display("FAIL s127xm128 got=%h exp=C080", p); end
    endtask

    task automatic test_zero();
        logic [15:0] p; int lat;
        run_op(8'h37, 8'h00, 1'b0, p, lat);
        checks++; if (p !== 16'h0000) begin failures++; $display("FAIL b0 got=%h exp=0000", p); end
        checks++; if (lat !== 2) begin failures++; $display("FAIL b0_lat got=%0d exp=2", lat); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL b0_done_width got=%b exp=0", done); end
        run_op(8'h00, 8'hFF, 1'b0, p, lat);
        checks++; if (p !== 16'h0000 || lat !== 9) begin failures++; $display("FAIL a0 got=%h lat=%0d exp=0000 lat=9", p, lat); end
        run_op(8'd7, 8'd3, 1'b0, p, lat);
        run_op(8'hFB, 8'h00, 1'b1, p, lat);
        checks++; if (p !== 16'h0000) begin failures++; $display("FAIL neg_zero got=%h exp=0000", p); end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        start = 1'b1; a = 8'd255; b = 8'd255; signed_mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL busy_after_accept got=%b exp=1", busy); end
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 3) begin
                start = 1'b1; a = 8'd1; b = 8'd1; signed_mode = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        checks++; if (!done || product !== 16'hFE01 || lat !== 9)
            begin failures++; $display("FAIL ignore_start got=%h lat=%0d exp=FE01 lat=9", product, lat); end
        start = 1'b1; a = 8'd3; b = 8'd4; signed_mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0)
            begin failures++; $display("FAIL b2b_accept busy=%b done=%b exp busy=1 done=0", busy, done); end
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++; if (!done || product !== 16'h000C || lat !== 4)
            begin failures++; $display("FAIL b2b_result got=%h lat=%0d exp=000C lat=4", product, lat); end
    endtask

    task automatic test_abort_and_w16();
        logic [31:0] p; int lat; int seen;
        @(negedge clk);
        start = 1'b1; a = 8'd200; b = 8'd201; signed_mode = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || product !== 16'h0000)
            begin failures++; $display("FAIL abort busy=%b done=%b product=%h exp 0/0/0000", busy, done, product); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL abort_no_done got=%0d active cycles exp=0", seen); end
        run_op16(16'hFFFF, 16'd2, 1'b1, p, lat);
        checks++; if (p !== 32'h0001FFFE) begin failures++; $display("FAIL w16_unsigned got=%h exp=0001FFFE", p); end
        checks++; if (lat !== 3) begin failures++; $display("FAIL w16_lat got=%0d exp=3", lat); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_zero();
        test_back_to_back();
        test_abort_and_w16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
